// File: rtl/serial_alu_sequencer.sv
// Word-level sequencer for a 1-bit ALU slice: shifts operands LSB-first, chains carry/borrow, assembles the result.
// Optional zero-result flag output is enabled with `define SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] R2_in,
    input  logic [WIDTH-1:0] R3_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] R1_out,
    output logic             c_out_final,
    output logic             slice_R2,
    output logic             slice_R3,
    output logic             slice_c_in,
    output logic [2:0]       slice_select,
    input  logic             slice_R1,
    input  logic             slice_c_out
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LESS = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             illegal_sel;
    logic             last_bit;
    logic             op_arith;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] final_word;

    assign accept      = (state_q == S_IDLE) && start;
    assign illegal_sel = (select == OP_ILL);
    assign last_bit    = (state_q == S_RUN) && (cnt_q == LAST_CNT);
    assign op_arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_LESS);
    // New slice bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_shift   = {slice_R1, res_q};
    assign final_word  = (op_q == OP_LESS) ? WIDTH'(slice_c_out) : res_shift;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = illegal_sel ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs; slice is driven only in RUN and never sees the illegal opcode
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        slice_R2     = 1'b0;
        slice_R3     = 1'b0;
        slice_c_in   = 1'b0;
        slice_select = OP_MOV;
        case (state_q)
            S_RUN: begin
                busy       = 1'b1;
                slice_R2   = a_q[0];
                slice_R3   = b_q[0];
                slice_c_in = carry_q;
                if (op_q == OP_LESS) begin
                    slice_select = OP_SUB;
                end else if (op_q != OP_ILL) begin
                    slice_select = op_q;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand shifters, carry chain, bit counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            op_q        <= OP_MOV;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            err         <= 1'b0;
            R1_out      <= '0;
            c_out_final <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero        <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= R2_in;
            b_q     <= R3_in;
            op_q    <= select;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            err     <= illegal_sel;
            if (illegal_sel) begin
                R1_out      <= '0;
                c_out_final <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                zero        <= 1'b1;
`endif
            end
        end else if (state_q == S_RUN) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            res_q   <= res_shift[WIDTH-1:1];
            carry_q <= op_arith ? slice_c_out : 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                R1_out      <= final_word;
                c_out_final <= op_arith ? slice_c_out : 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                zero        <= (final_word == '0);
`endif
            end
        end
    end

endmodule
